fp_minmax_stream: RTL and testbench

FP_MINMAX_STREAM -- requirements
Module: fp_minmax_stream

---
 rtl/fp_minmax_stream_pkg.sv | 37 +++
 rtl/fp_minmax_stream_order.sv | 48 ++++
 rtl/fp_minmax_stream.sv | 144 ++++++++++++++
 tb/tb_fp_minmax_stream.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_minmax_stream_pkg.sv
// Shared FP32 encodings, field bounds and FSM states
// for the streaming min/max reducer.
package fp_minmax_stream_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MAN_HI   = 22;
  localparam int MAN_LO   = 0;

  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic fp_is_nan(
    input logic [FP_W-1:0] x
  );
    return (&x[EXP_HI:EXP_LO]) &&
           (|x[MAN_HI:MAN_LO]);
  endfunction

  function automatic logic fp_is_zero(
    input logic [FP_W-1:0] x
  );
    return ~|x[EXP_HI:MAN_LO];
  endfunction

endpackage

// File: rtl/fp_minmax_stream_order.sv
// fp_order: combinational FP32 total-order compare.
// Ports: a, b -> lt, gt, eq (ordered only), nan (a or b NaN).
module fp_order
  import fp_minmax_stream_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt,
  output logic         eq,
  output logic         nan
);

  logic         a_nan;
  logic         b_nan;
  logic [W-1:0] ka;
  logic [W-1:0] kb;

  // Map to an unsigned key: positives get the top bit set,
  // negatives are inverted so larger magnitude sorts lower,
  // and both zeros share one key so +0 == -0.
  function automatic logic [W-1:0] key(
    input logic [W-1:0] x
  );
    logic [W-1:0] k;
    if (fp_is_zero(x))
      k = {1'b1, {(W-1){1'b0}}};
    else if (x[SIGN_BIT])
      k = ~x;
    else
      k = {1'b1, x[W-2:0]};
    return k;
  endfunction

  always_comb begin
    a_nan = fp_is_nan(a);
    b_nan = fp_is_nan(b);
    ka    = key(a);
    kb    = key(b);
    nan   = a_nan | b_nan;
    lt    = !nan && (ka < kb);
    gt    = !nan && (ka > kb);
    eq    = !nan && (ka == kb);
  end

endmodule

// File: rtl/fp_minmax_stream.sv
// Streaming FP32 min/max/count reducer over in_last bursts.
// In: clk, rst(async low), in_valid/in_data/in_last, out_ready.
// Out: in_ready, out_valid, out_min, out_max, out_count, out_inv.
module fp_minmax_stream
  import fp_minmax_stream_pkg::*;
#(
  parameter int W  = FP_W,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_min,
  output logic [W-1:0]  out_max,
  output logic [CW-1:0] out_count,
  output logic          out_inv
);

  state_t        state_q;
  state_t        state_d;
  logic          run_q;
  logic          accept;
  logic          done_hs;
  logic          x_nan;
  logic          have_q;
  logic          inv_q;
  logic [W-1:0]  min_q;
  logic [W-1:0]  max_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  logic mn_lt, mn_gt, mn_eq, mn_nan;
  logic mx_lt, mx_gt, mx_eq, mx_nan;
  logic unused_ord;

  fp_order #(.W(W)) u_ord_min (
    .a   (in_data),
    .b   (min_q),
    .lt  (mn_lt),
    .gt  (mn_gt),
    .eq  (mn_eq),
    .nan (mn_nan)
  );

  fp_order #(.W(W)) u_ord_max (
    .a   (in_data),
    .b   (max_q),
    .lt  (mx_lt),
    .gt  (mx_gt),
    .eq  (mx_eq),
    .nan (mx_nan)
  );

  assign unused_ord = ^{mn_gt, mn_eq, mn_nan,
                        mx_lt, mx_eq, mx_nan};

  assign x_nan   = fp_is_nan(in_data);
  assign accept  = in_valid && in_ready;
  assign done_hs = out_valid && out_ready;
  assign cnt_inc = (&cnt_q) ? cnt_q
                            : cnt_q + CW'(1);

  // run_q holds in_ready low until the first edge
  // after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept)
          state_d = in_last ? ST_DONE : ST_ACC;
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACC: in_ready  = run_q;
      ST_DONE:         out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // have_q: an ordered sample already seeded min/max.
  // A burst of only NaNs reports qNaN in both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      have_q <= 1'b0;
    end else if (done_hs) begin
      min_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      have_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_inc;
      inv_q <= inv_q | x_nan;
      if (!x_nan) begin
        have_q <= 1'b1;
        if (!have_q || mn_lt)
          min_q <= in_data;
        if (!have_q || mx_gt)
          max_q <= in_data;
      end else if (in_last && !have_q) begin
        min_q <= FP_QNAN;
        max_q <= FP_QNAN;
      end
    end
  end

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;
  assign out_inv   = inv_q;

endmodule

// File: tb/tb_fp_minmax_stream.sv
// Bench for fp_minmax_stream: random bursts against a
// real-valued reference model, plus directed corner bursts.
module tb_fp_minmax_stream;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_min;
  logic [W-1:0]  out_max;
  logic [CW-1:0] out_count;
  logic          out_inv;

  fp_minmax_stream #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count),
    .out_inv   (out_inv)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    int          cnt;
    logic        inv;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] cur[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Numeric value of an FP32 pattern; infinities become
  // huge reals so they order naturally.
  function automatic real to_real(input logic [31:0] x);
    int  e;
    real m;
    real v;
    e = int'(x[30:23]);
    m = real'(x[22:0]);
    if (e == 255)
      v = 1.0e300;
    else if (e == 0)
      v = m * (2.0 ** (-149));
    else
      v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -v : v;
  endfunction

  function automatic res_t model(input logic [31:0] s[$]);
    res_t r;
    bit   have;
    real  lo, hi, v;
    have  = 0;
    lo    = 0.0;
    hi    = 0.0;
    r.mn  = 32'h7FC0_0000;
    r.mx  = 32'h7FC0_0000;
    r.cnt = 0;
    r.inv = 1'b0;
    foreach (s[i]) begin
      if (r.cnt < CMAX) r.cnt++;
      if (is_nan(s[i])) begin
        r.inv = 1'b1;
      end else begin
        v = to_real(s[i]);
        if (!have || v < lo) begin lo = v; r.mn = s[i]; end
        if (!have || v > hi) begin hi = v; r.mx = s[i]; end
        have = 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    logic [31:0] pool [5];
    pool = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
             32'h0000_0000, 32'h8000_0000};
    x = $urandom;
    case ($urandom_range(7))
      0: x = {x[31], 31'h0};
      1: x = {x[31], 8'hFF, 23'h0};
      2: x = {x[31], 8'hFF, x[22:1], 1'b1};
      3: x = {x[31], 8'h00, x[22:0]};
      4, 5: x = pool[$urandom_range(4)];
      default: if (x[30:23] == 8'hFF) x[30] = 1'b0;
    endcase
    return x;
  endfunction

  // Checker: reset values, latency, result vs model,
  // stability while held, and clearing after handshake.
  logic        lat = 0, holding = 0, post = 0;
  logic [31:0] h_mn, h_mx;
  logic [CW-1:0] h_cnt;
  logic        h_inv;
  res_t        mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      cur.delete();
      exp_q.delete();
      lat = 0; holding = 0; post = 0;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_min", out_min, 0);
      chk("rst_max", out_max, 0);
      chk("rst_count", 32'(out_count), 0);
      chk("rst_inv", 32'(out_inv), 0);
    end else begin
      if (lat) begin
        chk("latency", 32'(out_valid), 1);
        lat = 0;
      end
      if (post) begin
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_count", 32'(out_count), 0);
        chk("idle_inv", 32'(out_inv), 0);
        post = 0;
      end
      if (out_valid) begin
        chk("done_in_ready", 32'(in_ready), 0);
        if (!holding) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(out_valid), 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("min", out_min, mon_e.mn);
            chk("max", out_max, mon_e.mx);
            chk("count", 32'(out_count), 32'(mon_e.cnt));
            chk("inv", 32'(out_inv), 32'(mon_e.inv));
            h_mn = out_min; h_mx = out_max;
            h_cnt = out_count; h_inv = out_inv;
            holding = 1;
          end
        end else begin
          chk("hold_min", out_min, h_mn);
          chk("hold_max", out_max, h_mx);
          chk("hold_count", 32'(out_count), 32'(h_cnt));
          chk("hold_inv", 32'(out_inv), 32'(h_inv));
        end
        if (out_ready) begin
          holding = 0;
          post = 1;
        end
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last) begin
          exp_q.push_back(model(cur));
          cur.delete();
          lat = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d, input logic l);
    int n;
    while ($urandom_range(3) == 0) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_burst(input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 1);
    repeat (hold) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_last   = 1'b1;
      out_ready = 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_q(input logic [31:0] s[$], input int hold);
    foreach (s[i]) push_one(s[i], i == s.size() - 1);
    finish_burst(hold);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    release_rst();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q[$];
    res_t        m;
    int          len;

    rst = 1'b0;
    repeat (3) tick();

    q = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
    m = model(q);
    chk("pin_a_min", m.mn, 32'hC000_0000);
    chk("pin_a_max", m.mx, 32'h4040_0000);
    chk("pin_a_cnt", 32'(m.cnt), 3);
    chk("pin_a_inv", 32'(m.inv), 0);
    q = '{32'h8000_0000, 32'h0000_0000};
    m = model(q);
    chk("pin_b_min", m.mn, 32'h8000_0000);
    chk("pin_b_max", m.mx, 32'h8000_0000);
    chk("pin_b_cnt", 32'(m.cnt), 2);
    q = '{32'h7FC0_0001, 32'hFF80_0000, 32'h4120_0000};
    m = model(q);
    chk("pin_c_min", m.mn, 32'hFF80_0000);
    chk("pin_c_max", m.mx, 32'h4120_0000);
    chk("pin_c_inv", 32'(m.inv), 1);
    q = '{32'h7FC0_0000};
    m = model(q);
    chk("pin_d_min", m.mn, 32'h7FC0_0000);
    chk("pin_d_max", m.mx, 32'h7FC0_0000);
    chk("pin_d_cnt", 32'(m.cnt), 1);
    q.delete();
    repeat (20) q.push_back(32'h3F80_0000);
    m = model(q);
    chk("pin_sat_cnt", 32'(m.cnt), CMAX);

    release_rst();

    q = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
    send_q(q, 5);
    q = '{32'h8000_0000, 32'h0000_0000};
    send_q(q, 0);
    q = '{32'h7FC0_0001, 32'hFF80_0000, 32'h4120_0000};
    send_q(q, 1);
    q = '{32'h7FC0_0000};
    send_q(q, 2);

    push_one(32'h3F80_0000, 1'b0);
    push_one(32'h4040_0000, 1'b0);
    do_reset();
    q = '{32'h4000_0000};
    send_q(q, 1);

    repeat (40) begin
      len = $urandom_range(1, 8);
      q.delete();
      repeat (len) q.push_back(rnd_fp());
      send_q(q, $urandom_range(0, 3));
    end

    q.delete();
    repeat (20) q.push_back(rnd_fp());
    send_q(q, 1);

    repeat (3) tick();
    chk("drain_queue", 32'(exp_q.size()), 0);
    chk("drain_hold", 32'(holding), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
